// File: rtl/panel_step_ctrl_if.sv
// Signal bundle between the front-panel switch conditioners / CPU and panel_step_ctrl.
// The master modport is the controller side; slave is the panel/CPU side.
interface panel_step_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             sw_posedge;
    logic             sw_double;
    logic             sw_hold;
    logic             sw_repeat;
    logic             rst_req;
    logic             cpu_halted;
    logic             step_ack;
    logic             cpu_run;
    logic             step_req;
    logic             cpu_reset;
    logic [2:0]       mode;
    logic [CNT_W-1:0] step_count;

    modport master (
        input  sw_posedge,
        input  sw_double,
        input  sw_hold,
        input  sw_repeat,
        input  rst_req,
        input  cpu_halted,
        input  step_ack,
        output cpu_run,
        output step_req,
        output cpu_reset,
        output mode,
        output step_count
    );

    modport slave (
        output sw_posedge,
        output sw_double,
        output sw_hold,
        output sw_repeat,
        output rst_req,
        output cpu_halted,
        output step_ack,
        input  cpu_run,
        input  step_req,
        input  cpu_reset,
        input  mode,
        input  step_count
    );
endinterface

// File: rtl/panel_step_ctrl.sv
// Front-panel run/step controller: turns RUN/STEP switch events into CPU run level,
// single-step handshake and a timed CPU reset pulse.
module panel_step_ctrl #(
    parameter int unsigned CLK_FRQ   = 27_000_000,
    parameter int unsigned RESET_MS  = 20,
    parameter int unsigned DEFER_CLK = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    panel_step_ctrl_if.master bus
);

    localparam int unsigned RESET_CLK = (CLK_FRQ / 1000) * RESET_MS;
    localparam int unsigned TMR_MAX   = (RESET_CLK > DEFER_CLK) ? RESET_CLK : DEFER_CLK;
    localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        StRst  = 3'd0,
        StHalt = 3'd1,
        StPend = 3'd2,
        StStep = 3'd3,
        StRun  = 3'd4,
        StAuto = 3'd5
    } state_e;

    state_e             r_state;
    logic [TMR_W-1:0]   r_tmr;
    logic               r_step_req;
    logic               r_cpu_run;
    logic               r_cpu_reset;
    logic [CNT_W-1:0]   r_step_count;
    logic               r_double_q;
    logic               r_hold_q;
    logic               r_repeat_q;

    state_e             w_state_nx;
    logic [TMR_W-1:0]   w_tmr_nx;
    logic               w_step_req_nx;
    logic               w_count_inc;
    logic               w_cpu_run_nx;
    logic               w_cpu_reset_nx;
    logic               w_double_rise;
    logic               w_hold_rise;
    logic               w_repeat_rise;
    logic               w_ack;
    logic               w_auto_exit;

    assign w_double_rise = bus.sw_double & ~r_double_q;
    assign w_hold_rise   = bus.sw_hold   & ~r_hold_q;
    assign w_repeat_rise = bus.sw_repeat & ~r_repeat_q;
    // An ack only counts while a step is actually outstanding.
    assign w_ack         = r_step_req & bus.step_ack;
    assign w_auto_exit   = (~r_step_req | w_ack) & (~bus.sw_hold | bus.cpu_halted);

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StRst;
            r_tmr        <= '0;
            r_step_req   <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_step_count <= '0;
            r_double_q   <= 1'b0;
            r_hold_q     <= 1'b0;
            r_repeat_q   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_tmr       <= w_tmr_nx;
            r_step_req  <= w_step_req_nx;
            r_cpu_run   <= w_cpu_run_nx;
            r_cpu_reset <= w_cpu_reset_nx;
            r_double_q  <= bus.sw_double;
            r_hold_q    <= bus.sw_hold;
            r_repeat_q  <= bus.sw_repeat;
            if (w_count_inc) begin
                r_step_count <= r_step_count + 1'b1;
            end
        end
    end

    // Next-state logic; rst_req overrides everything, including a pending ack.
    always_comb begin
        w_state_nx    = r_state;
        w_tmr_nx      = r_tmr;
        w_step_req_nx = r_step_req;
        w_count_inc   = 1'b0;
        if (bus.rst_req) begin
            w_state_nx    = StRst;
            w_tmr_nx      = '0;
            w_step_req_nx = 1'b0;
        end else begin
            unique case (r_state)
                StRst: begin
                    if (r_tmr == TMR_W'(RESET_CLK - 1)) begin
                        w_state_nx = StHalt;
                        w_tmr_nx   = '0;
                    end else begin
                        w_tmr_nx = r_tmr + 1'b1;
                    end
                end
                StHalt: begin
                    if (w_hold_rise) begin
                        w_state_nx = StAuto;
                    end else if (w_double_rise) begin
                        w_state_nx = StRun;
                    end else if (bus.sw_posedge) begin
                        w_state_nx = StPend;
                        w_tmr_nx   = '0;
                    end
                end
                StPend: begin
                    // A click is held back so a following double-click can claim it.
                    if (w_hold_rise) begin
                        w_state_nx = StAuto;
                    end else if (w_double_rise) begin
                        w_state_nx = StRun;
                    end else if (r_tmr == TMR_W'(DEFER_CLK - 1)) begin
                        w_state_nx    = StStep;
                        w_step_req_nx = 1'b1;
                    end else begin
                        w_tmr_nx = r_tmr + 1'b1;
                    end
                end
                StStep: begin
                    if (w_ack) begin
                        w_state_nx    = StHalt;
                        w_step_req_nx = 1'b0;
                        w_count_inc   = 1'b1;
                    end
                end
                StRun: begin
                    if (bus.sw_posedge || bus.cpu_halted) begin
                        w_state_nx = StHalt;
                    end
                end
                StAuto: begin
                    if (w_ack) begin
                        w_step_req_nx = 1'b0;
                        w_count_inc   = 1'b1;
                    end else if (!r_step_req && w_repeat_rise && bus.sw_hold) begin
                        w_step_req_nx = 1'b1;
                    end
                    // Leave only with no step outstanding after this edge.
                    if (w_auto_exit) begin
                        w_state_nx    = StHalt;
                        w_step_req_nx = 1'b0;
                    end
                end
                default: begin
                    w_state_nx    = StRst;
                    w_tmr_nx      = '0;
                    w_step_req_nx = 1'b0;
                end
            endcase
        end
    end

    // Output decode of the next state, registered above
    always_comb begin
        w_cpu_run_nx   = (w_state_nx == StRun);
        w_cpu_reset_nx = (w_state_nx == StRst);
    end

    assign bus.cpu_run    = r_cpu_run;
    assign bus.step_req   = r_step_req;
    assign bus.cpu_reset  = r_cpu_reset;
    assign bus.mode       = r_state;
    assign bus.step_count = r_step_count;

endmodule

// File: tb/tb_panel_step_ctrl.sv
// Randomised and directed bench for panel_step_ctrl against a cycle-level behavioural model.
module tb_panel_step_ctrl;

    localparam int unsigned CLK_FRQ   = 1000;
    localparam int unsigned RESET_MS  = 20;
    localparam int unsigned DEFER_CLK = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned RESET_CLK = (CLK_FRQ / 1000) * RESET_MS;

    localparam int M_RST  = 0;
    localparam int M_HALT = 1;
    localparam int M_PEND = 2;
    localparam int M_STEP = 3;
    localparam int M_RUN  = 4;
    localparam int M_AUTO = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    panel_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    panel_step_ctrl #(
        .CLK_FRQ   (CLK_FRQ),
        .RESET_MS  (RESET_MS),
        .DEFER_CLK (DEFER_CLK),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode  = M_RST;
    int m_left  = 0;
    int m_count = 0;
    bit m_req   = 1'b0;
    bit m_ph    = 1'b0;
    bit m_pd    = 1'b0;
    bit m_pr    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model in terms of remaining cycles per phase, evaluated on the inputs seen at the edge.
    task automatic model_edge();
        bit hr, dr, rr, ack, req_before;
        hr   = bus.sw_hold   && !m_ph;
        dr   = bus.sw_double && !m_pd;
        rr   = bus.sw_repeat && !m_pr;
        ack  = m_req && bus.step_ack;
        m_ph = bus.sw_hold;
        m_pd = bus.sw_double;
        m_pr = bus.sw_repeat;
        req_before = m_req;
        if (reset) begin
            m_mode = M_RST; m_left = RESET_CLK - 1; m_req = 0; m_count = 0;
            m_ph = 0; m_pd = 0; m_pr = 0;
        end else if (bus.rst_req) begin
            m_mode = M_RST; m_left = RESET_CLK - 1; m_req = 0;
        end else begin
            case (m_mode)
                M_RST:  if (m_left == 0) m_mode = M_HALT; else m_left--;
                M_HALT: begin
                    if (hr) m_mode = M_AUTO;
                    else if (dr) m_mode = M_RUN;
                    else if (bus.sw_posedge) begin m_mode = M_PEND; m_left = DEFER_CLK - 1; end
                end
                M_PEND: begin
                    if (hr) m_mode = M_AUTO;
                    else if (dr) m_mode = M_RUN;
                    else if (m_left == 0) begin m_mode = M_STEP; m_req = 1; end
                    else m_left--;
                end
                M_STEP: if (ack) begin
                    m_req = 0; m_count = (m_count + 1) % (1 << CNT_W); m_mode = M_HALT;
                end
                M_RUN:  if (bus.sw_posedge || bus.cpu_halted) m_mode = M_HALT;
                M_AUTO: begin
                    if (ack) begin m_req = 0; m_count = (m_count + 1) % (1 << CNT_W); end
                    if (!m_req && (!bus.sw_hold || bus.cpu_halted)) m_mode = M_HALT;
                    else if (!req_before && rr && bus.sw_hold) m_req = 1;
                end
                default: m_mode = M_RST;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("mode", 32'(bus.mode), 32'(m_mode));
        check("step_req", 32'(bus.step_req), 32'(m_req));
        check("cpu_run", 32'(bus.cpu_run), 32'(m_mode == M_RUN));
        check("cpu_reset", 32'(bus.cpu_reset), 32'(m_mode == M_RST));
        check("step_count", 32'(bus.step_count), 32'(m_count));
    endtask

    int n;

    initial begin
        bus.sw_posedge = 0; bus.sw_double = 0; bus.sw_hold = 0; bus.sw_repeat = 0;
        bus.rst_req = 0; bus.cpu_halted = 0; bus.step_ack = 0;

        // Reset pulse length
        tick(); tick();
        reset = 0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.cpu_reset) break;
            n++;
            tick();
        end
        check("rst_len", 32'(n), 32'(RESET_CLK));
        check("rst_done_mode", 32'(bus.mode), 32'(M_HALT));

        // Single click becomes a step after the defer window
        bus.sw_posedge = 1; tick(); bus.sw_posedge = 0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.step_req) break;
            n++;
            tick();
        end
        check("defer_len", 32'(n), 32'(DEFER_CLK));
        tick(); tick();
        bus.step_ack = 1; tick(); bus.step_ack = 0;
        check("step_cnt", 32'(bus.step_count), 32'd1);
        check("step_mode", 32'(bus.mode), 32'(M_HALT));

        // Click followed by double-click runs the CPU
        bus.sw_posedge = 1; tick(); bus.sw_posedge = 0;
        tick(); tick();
        bus.sw_double = 1; tick();
        check("run_on", 32'(bus.cpu_run), 32'd1);
        bus.cpu_halted = 1; tick(); bus.cpu_halted = 0; bus.sw_double = 0;
        check("run_off", 32'(bus.cpu_run), 32'd0);
        check("run_halt_mode", 32'(bus.mode), 32'(M_HALT));

        // Auto-repeat while held
        bus.sw_hold = 1; tick();
        for (int k = 0; k < 4; k++) begin
            bus.sw_repeat = 1; tick(); bus.sw_repeat = 0; tick();
            bus.step_ack = 1; tick(); bus.step_ack = 0;
        end
        check("auto4_cnt", 32'(bus.step_count), 32'd5);
        bus.sw_repeat = 1; tick(); bus.sw_repeat = 0; tick();
        bus.sw_repeat = 1; tick();
        bus.step_ack = 1; tick(); bus.step_ack = 0; bus.sw_repeat = 0; tick();
        check("auto_drop_cnt", 32'(bus.step_count), 32'd6);
        check("auto_drop_req", 32'(bus.step_req), 32'd0);
        bus.sw_hold = 0; tick();
        check("auto_exit", 32'(bus.mode), 32'(M_HALT));

        // rst_req while a step is outstanding, then re-armed mid-pulse
        bus.sw_posedge = 1; tick(); bus.sw_posedge = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.step_req) break;
            tick();
        end
        bus.rst_req = 1; tick(); bus.rst_req = 0;
        check("rst_drop_req", 32'(bus.step_req), 32'd0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.cpu_reset) break;
            n++;
            if (n == 10) bus.rst_req = 1;
            tick();
            bus.rst_req = 0;
        end
        check("rst_extend", 32'(n), 32'(RESET_CLK + 10));

        // Counter wrap and ack colliding with rst_req
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.cpu_reset) break;
            tick();
        end
        bus.sw_hold = 1; tick();
        for (int k = 0; k < 16; k++) begin
            bus.sw_repeat = 1; tick(); bus.sw_repeat = 0;
            bus.step_ack = 1; tick(); bus.step_ack = 0;
        end
        check("wrap_cnt", 32'(bus.step_count), 32'd0);
        bus.sw_repeat = 1; tick(); bus.sw_repeat = 0;
        bus.step_ack = 1; bus.rst_req = 1; tick(); bus.step_ack = 0; bus.rst_req = 0;
        check("ack_rst_cnt", 32'(bus.step_count), 32'd0);
        check("ack_rst_mode", 32'(bus.mode), 32'(M_RST));
        bus.sw_hold = 0;

        // Random phase
        for (int c = 0; c < 2500; c++) begin
            bus.sw_posedge = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) bus.sw_double = !bus.sw_double;
            if ($urandom_range(0, 59) == 0) bus.sw_hold = !bus.sw_hold;
            if ($urandom_range(0, 2) == 0) bus.sw_repeat = !bus.sw_repeat;
            bus.step_ack   = ($urandom_range(0, 3) == 0);
            bus.cpu_halted = ($urandom_range(0, 79) == 0);
            bus.rst_req    = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/panel_step_ctrl.md
Name: panel_step_ctrl

Overview:
- Front-panel run/step controller that sits directly downstream of the switch conditioners.
- Consumes the logical switch events (posedge, double, hold, repeat) and a reset-request event.
- Drives the CPU run level, the single-step request handshake and the CPU reset pulse.
- Provides a mode code and a step counter for the panel LEDs.

Parameters:
- CLK_FRQ, 27_000_000, clock frequency (Hz).
- RESET_MS, 20, CPU reset pulse length (ms); RESET_CLK = (CLK_FRQ/1000)*RESET_MS.
- DEFER_CLK, 8, cycles a single click waits for a possible sw_double before it is committed as a step.
- CNT_W, 16, step_count width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sw_posedge  in  1  one-cycle pulse, debounced press of the RUN/STEP switch.
- sw_double  in  1  level, double-click of the RUN/STEP switch.
- sw_hold  in  1  level, RUN/STEP switch held.
- sw_repeat  in  1  level, repeat square wave of the RUN/STEP switch.
- rst_req  in  1  one-cycle pulse from the RESET switch.
- cpu_halted  in  1  level, CPU executed HLT.
- step_ack  in  1  CPU finished the requested instruction.
- cpu_run  out  1  CPU free-running enable.
- step_req  out  1  single-instruction request, level.
- cpu_reset  out  1  CPU reset, active-high.
- mode  out  3  state code: RST=0, HALT=1, PEND=2, STEP=3, RUN=4, AUTO=5.
- step_count  out  CNT_W  number of acknowledged steps, wraps.

Behaviour:
- All outputs registered. Internal rising-edge detectors on sw_double, sw_hold and sw_repeat (the "rise" events below).
- Reset: on the next clk, state=RST, rst counter=0, cpu_reset=1, cpu_run=0, step_req=0, step_count=0, mode=0.
- rst_req in any state: next state RST and the counter restarts, including mid-RST. step_req is dropped without waiting for step_ack. rst_req has top priority.
- RST: cpu_reset=1 for exactly RESET_CLK cycles, then HALT. All switch events are ignored.
- HALT: priority is hold rise > double rise > sw_posedge.
  - hold rise -> AUTO.
  - double rise -> RUN.
  - sw_posedge -> PEND with defer counter=0.
  - cpu_halted is ignored.
- PEND:
  - double rise within DEFER_CLK cycles -> RUN.
  - hold rise -> AUTO.
  - Otherwise, when the counter reaches DEFER_CLK -> STEP with step_req=1.
  - The first click of a double click therefore produces one step (accepted behaviour).
- STEP:
  - step_req stays 1 until step_ack is sampled 1.
  - Next cycle: step_req=0, step_count+1, state HALT.
  - Switch events are ignored while in STEP.
- RUN:
  - cpu_run=1.
  - sw_posedge or cpu_halted -> HALT; cpu_run drops the next cycle.
  - A double rise while in RUN is ignored.
- AUTO:
  - Each sw_repeat rise while sw_hold=1 and step_req=0 sets step_req=1.
  - A repeat rise while a step is outstanding is dropped, not queued.
  - Each ack: step_req=0 and step_count+1, in the same manner as STEP.
  - Exit to HALT when sw_hold=0 or cpu_halted=1, and only once step_req=0. An outstanding step completes first.
- step_ack when step_req=0 is ignored. step_count wraps from all-ones to 0.
- Simultaneous ack and rst_req: RST wins and step_count is not incremented.
- mode reflects the current registered state.

Test Plan:
- CLK_FRQ=1000, RESET_MS=20: pulse reset -> cpu_reset=1 for exactly 20 cycles, mode=0, then mode=1, all other outputs 0.
- In HALT, one sw_posedge, no double -> after 8 cycles step_req=1; step_ack 3 cycles later -> step_req=0 next cycle, step_count=1, mode=1.
- In HALT, sw_posedge then sw_double rise 3 cycles later -> no step_req, cpu_run=1 within 1 cycle; cpu_halted=1 -> cpu_run=0 next cycle, mode=1.
- In HALT, sw_hold rise, 4 sw_repeat rises each acked in 2 cycles -> step_count=4; a fifth rise during an outstanding step -> dropped, count stays 5 after the fifth ack; sw_hold=0 -> HALT.
- In STEP with step_req=1 and no ack, rst_req -> step_req=0 next cycle, cpu_reset=1 for 20 cycles; rst_req again at cycle 10 -> the pulse extends to 30 total.
- step_count preset near wrap (CNT_W=4, 15 acks then 1 more) -> count reads 0; ack and rst_req in the same cycle -> count unchanged.
